// File: rtl/stream_demux1to2_if.sv
// Handshake bundle for the 1-to-2 stream demultiplexer: one input stream,
// two output channels and their delivered-beat counters.
interface stream_demux1to2_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
endinterface

// File: rtl/stream_demux1to2.sv
// Routes one input stream to two independent 2-entry FIFOs selected by in_sel,
// and counts beats delivered on each output channel.
module stream_demux1to2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    stream_demux1to2_if.slave bus
);
    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    // Each FIFO is a two-slot shift register so the head is always a flop.
    logic [WIDTH-1:0] head_r    [2];
    logic [WIDTH-1:0] tail_r    [2];
    logic [WIDTH-1:0] head_nx_s [2];
    logic [WIDTH-1:0] tail_nx_s [2];
    logic [1:0]       occ_r     [2];
    logic [1:0]       occ_nx_s  [2];
    logic [7:0]       cnt_r     [2];
    logic [7:0]       cnt_nx_s  [2];
    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic [1:0]       out_ready_s;
    logic             in_ready_s;

    assign out_ready_s = {bus.out1_ready, bus.out0_ready};
    // Registered occupancy only, so a full FIFO refuses a push even while it is being popped.
    assign in_ready_s  = rst_n && (occ_r[bus.in_sel] != FULL_OCC);

    // Next-state of both FIFOs and counters from push/pop handshakes.
    always_comb begin
        push_s = 2'b00;
        pop_s  = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            head_nx_s[ch] = head_r[ch];
            tail_nx_s[ch] = tail_r[ch];
            occ_nx_s[ch]  = occ_r[ch];
            push_s[ch]    = bus.in_valid && in_ready_s && (int'(bus.in_sel) == ch);
            pop_s[ch]     = (occ_r[ch] != 2'd0) && out_ready_s[ch];
            cnt_nx_s[ch]  = cnt_r[ch] + {7'd0, pop_s[ch]};
            case ({push_s[ch], pop_s[ch]})
                2'b10: begin
                    if (occ_r[ch] == 2'd0) begin
                        head_nx_s[ch] = bus.in_data;
                    end else begin
                        tail_nx_s[ch] = bus.in_data;
                    end
                    occ_nx_s[ch] = occ_r[ch] + 2'd1;
                end
                2'b01: begin
                    head_nx_s[ch] = tail_r[ch];
                    occ_nx_s[ch]  = occ_r[ch] - 2'd1;
                end
                2'b11: begin
                    if (occ_r[ch] == 2'd1) begin
                        head_nx_s[ch] = bus.in_data;
                    end else begin
                        head_nx_s[ch] = tail_r[ch];
                        tail_nx_s[ch] = bus.in_data;
                    end
                end
                default: begin
                    occ_nx_s[ch] = occ_r[ch];
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                head_r[ch] <= {WIDTH{1'b0}};
                tail_r[ch] <= {WIDTH{1'b0}};
                occ_r[ch]  <= 2'd0;
                cnt_r[ch]  <= 8'd0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                head_r[ch] <= head_nx_s[ch];
                tail_r[ch] <= tail_nx_s[ch];
                occ_r[ch]  <= occ_nx_s[ch];
                cnt_r[ch]  <= cnt_nx_s[ch];
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out0_valid = (occ_r[0] != 2'd0);
    assign bus.out1_valid = (occ_r[1] != 2'd0);
    assign bus.out0_data  = head_r[0];
    assign bus.out1_data  = head_r[1];
    assign bus.cnt0       = cnt_r[0];
    assign bus.cnt1       = cnt_r[1];
endmodule

// File: tb/tb_stream_demux1to2.sv
// Randomized and directed bench for stream_demux1to2 against a queue-based reference model.
module tb_stream_demux1to2;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int   c0;
    int   c1;
    bit   zero_chk;

    stream_demux1to2_if #(.WIDTH(8)) bus ();

    stream_demux1to2 #(.WIDTH(8), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, compare against model, then advance the model across the edge.
    task automatic cyc(input logic rst, input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
        logic exp_rdy;
        logic push;
        logic pop0;
        logic pop1;
        rst_n          = rst;
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        #1;
        exp_rdy = rst && ((s ? q1.size() : q0.size()) < 2);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() > 0));
        chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() > 0));
        if (q0.size() > 0) chk("out0_data", 32'(bus.out0_data), 32'(q0[0]));
        if (q1.size() > 0) chk("out1_data", 32'(bus.out1_data), 32'(q1[0]));
        chk("cnt0", 32'(bus.cnt0), 32'(c0));
        chk("cnt1", 32'(bus.cnt1), 32'(c1));
        if (zero_chk) begin
            chk("rst_out0_data", 32'(bus.out0_data), 32'd0);
            chk("rst_out1_data", 32'(bus.out1_data), 32'd0);
            zero_chk = 1'b0;
        end
        push = v && exp_rdy;
        pop0 = r0 && (q0.size() > 0);
        pop1 = r1 && (q1.size() > 0);
        @(posedge clk);
        if (!rst) begin
            q0.delete();
            q1.delete();
            c0 = 0;
            c1 = 0;
            zero_chk = 1'b1;
        end else begin
            if (pop0) begin
                void'(q0.pop_front());
                c0 = (c0 + 1) % 256;
            end
            if (pop1) begin
                void'(q1.pop_front());
                c1 = (c1 + 1) % 256;
            end
            if (push) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        c0 = 0;
        c1 = 0;
        zero_chk = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 1'b0;
        bus.in_data = 8'h00;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Basic routing
        cyc(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        chk("route_out0", 32'(bus.out0_data), 32'h11);
        cyc(1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        chk("route_out1", 32'(bus.out1_data), 32'h22);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("route_cnt0", 32'(bus.cnt0), 32'd1);
        chk("route_cnt1", 32'(bus.cnt1), 32'd1);

        // Full and backpressure on channel 0
        cyc(1'b1, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b0);
        chk("bp_head_a2", 32'(bus.out0_data), 32'hA2);

        // Independence: channel 0 refilled and stalled, channel 1 still flows
        cyc(1'b1, 1'b1, 1'b0, 8'hB0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        chk("ind_out1", 32'(bus.out1_data), 32'h55);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push/pop at occupancy 1
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        chk("pp_valid", 32'(bus.out0_valid), 32'd1);
        chk("pp_data", 32'(bus.out0_data), 32'h02);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Counter wrap on channel 1
        for (int i = 0; i < 258; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // Reset with both FIFOs full
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
        chk("rst_valid0", 32'(bus.out0_valid), 32'd0);
        chk("rst_valid1", 32'(bus.out1_valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_demux1to2.md
STREAM_DEMUX1TO2 -- requirements
Module: stream_demux1to2

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits of the input and both output channels.
REQ-002 Parameter DEPTH, fixed at 2: entries per output FIFO; no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 in_data  input  WIDTH  input payload.
REQ-008 in_sel  input  1  destination of the input beat: 0 selects channel 0, 1 selects channel 1.
REQ-009 out0_valid / out1_valid  output  1 each  channel holds a beat.
REQ-010 out0_ready / out1_ready  input  1 each  downstream consumer takes the beat.
REQ-011 out0_data / out1_data  output  WIDTH each  channel payload, the FIFO head.
REQ-012 cnt0 / cnt1  output  8 each  count of beats delivered on each channel.

Function
REQ-013 An input transfer shall occur when in_valid=1 and in_ready=1 on the same rising edge.
REQ-014 An output transfer on channel N shall occur when outN_valid=1 and outN_ready=1 on the same rising edge.
REQ-015 in_ready shall equal NOT full of the FIFO selected by the current in_sel, where full means registered occupancy = 2.
- in_ready is combinational from in_sel and registered occupancy only.
- in_ready shall not depend on outN_ready, so a full FIFO being popped in the same cycle still refuses the push.
REQ-016 An accepted beat shall be written to the tail of the selected FIFO only; the other FIFO is unchanged.
REQ-017 outN_valid shall be 1 if and only if the registered occupancy of FIFO N is greater than 0.
REQ-018 outN_data shall be the FIFO N head; its value is don't-care while outN_valid=0.
REQ-019 Latency: a beat accepted into an empty FIFO shall appear on outN_valid/outN_data on the next cycle; there is no combinational pass-through.
REQ-020 Ordering: beats within each channel shall emerge in acceptance order; there is no ordering relation between channels.
REQ-021 Simultaneous push and pop on one FIFO with occupancy 1 shall leave occupancy at 1, with the new beat as head on the next cycle.
REQ-022 Occupancy per FIFO shall take values 0, 1 or 2 only and shall never overflow or underflow.
REQ-023 outN_valid, once asserted, shall stay asserted with stable data until that beat transfers.
REQ-024 cntN shall increment by 1 on each channel-N output transfer and wrap from 255 to 0 without saturation.
REQ-025 The two output channels shall operate independently: a stalled channel shall not block transfers destined for the other channel.

Reset
REQ-026 While rst_n=0 at a rising edge, both FIFOs shall empty, with out0_valid=out1_valid=0.
REQ-027 While rst_n=0 at a rising edge, cnt0=cnt1=0 and out0_data=out1_data=0.
REQ-028 in_ready shall be 0 while rst_n=0 and 1 from the first cycle after rst_n returns high.
REQ-029 Reset asserted mid-operation shall discard all buffered beats.
- Any handshake coinciding with the reset edge shall be ignored.
- No partial beat shall emerge after reset.

Verification
REQ-030 Basic routing: push 0x11 with sel=0, then 0x22 with sel=1, both outN_ready=1.
- out0 shows 0x11 one cycle after its push; out1 shows 0x22 one cycle after its push.
- cnt0=1 and cnt1=1 afterwards.
REQ-031 Full and backpressure: out0_ready=0; push 0xA0, 0xA1, 0xA2 with sel=0.
- in_ready drops after 2 accepts; 0xA2 is held.
- Raising out0_ready drains 0xA0, then 0xA1; 0xA2 is accepted only once occupancy is below 2.
REQ-032 Independence: channel 0 is full and stalled; push 0x55 with sel=1.
- in_ready=1 and out1 delivers 0x55.
- Channel 0 contents and occupancy are unchanged.
REQ-033 Simultaneous push/pop: channel 0 holds one entry, 0x01; push 0x02 and pop in the same cycle.
- Next cycle out0_valid=1 and out0_data=0x02.
REQ-034 Counter wrap: deliver 256 beats on channel 1 -> cnt1 reads 0; deliver 1 more -> cnt1 reads 1.
REQ-035 Reset mid-stream: both FIFOs full, then rst_n=0 for one edge.
- Next cycle: both outN_valid=0, cnt0=cnt1=0, in_ready=1.
